// File: rtl/ycconfig_row_if.sv
// Host-side bundle for one configuration row: code push handshake, commit
// request/status and the decoded per-cell controls.
interface ycconfig_row_if #(
    parameter int NCELLS = 8
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [2:0]            cfg_word;
    logic                  commit;
    logic                  commit_done;
    logic                  commit_err;
    logic                  loaded;
    logic                  cbitout;
    logic [9*NCELLS-1:0]   ctrl;

    modport master (
        output cfg_valid, cfg_word, commit,
        input  cfg_ready, commit_done, commit_err, loaded, cbitout, ctrl
    );

    modport slave (
        input  cfg_valid, cfg_word, commit,
        output cfg_ready, commit_done, commit_err, loaded, cbitout, ctrl
    );
endinterface

// File: rtl/ycconfig_row.sv
// Row configuration loader: serialises 3-bit cell codes into a staging chain,
// commits staging to the active register atomically, decodes each cell.

module ycconfig_cell_dec (
    input  logic [2:0] code,
    output logic [8:0] ctrl
);
    // {empty,hblock,hbypass,hmatch0,hmatch1,vblock,vbypass,vmatch0,vmatch1}
    always_comb begin
        ctrl = 9'b110001000;
        case (code)
            3'b000:  ctrl = 9'b110001000;
            3'b001:  ctrl = 9'b000110011;
            3'b010:  ctrl = 9'b001001000;
            3'b011:  ctrl = 9'b010000100;
            3'b100:  ctrl = 9'b000110001;
            3'b101:  ctrl = 9'b000110010;
            3'b110:  ctrl = 9'b000010011;
            3'b111:  ctrl = 9'b000100011;
            default: ctrl = 9'b110001000;
        endcase
    end
endmodule

module ycconfig_row #(
    parameter int NCELLS = 8,
    parameter bit SHADOW = 1'b1
) (
    input  logic          confclk,
    input  logic          reset,
    ycconfig_row_if.slave bus
);
    localparam int SW = 3 * NCELLS;
    localparam int CW = $clog2(NCELLS + 1);
    localparam logic [CW-1:0] FULL = CW'(NCELLS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [SW-1:0] stage_q,  stage_d;
    logic [SW-1:0] active_q, active_d;
    logic [CW-1:0] count_q,  count_d;
    logic [2:0]    word_q,   word_d;
    logic [1:0]    bitcnt_q, bitcnt_d;

    logic [SW-1:0]       dec_src;
    logic [9*NCELLS-1:0] ctrl_w;

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        active_d = active_q;
        count_d  = count_q;
        word_d   = word_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                // commit has priority; a word offered alongside it is refused
                if (bus.commit) begin
                    state_d = COMMIT;
                end else if (bus.cfg_valid) begin
                    word_d   = bus.cfg_word;
                    bitcnt_d = 2'd0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // word is shifted out MSB first; word_q is consumed as it goes
                stage_d  = {stage_q[SW-2:0], word_q[2]};
                word_d   = {word_q[1:0], 1'b0};
                bitcnt_d = bitcnt_q + 2'd1;
                if (bitcnt_q == 2'd2) begin
                    bitcnt_d = 2'd0;
                    state_d  = IDLE;
                    if (count_q != FULL) count_d = count_q + 1'b1;
                end
            end
            COMMIT: begin
                if (SHADOW) active_d = stage_q;
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge confclk) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            active_q <= '0;
            count_q  <= '0;
            word_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            active_q <= active_d;
            count_q  <= count_d;
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign bus.cfg_ready   = ~reset & (state_q == IDLE) & ~bus.commit;
    assign bus.commit_done = ~reset & (state_q == COMMIT);
    assign bus.commit_err  = bus.commit_done & (count_q != FULL);
    assign bus.loaded      = ~reset & (count_q == FULL);
    assign bus.cbitout     = ~reset & stage_q[SW-1];

    // Forcing all-zero codes during reset shows every cell as empty at once.
    assign dec_src = reset ? '0 : (SHADOW ? active_q : stage_q);

    for (genvar k = 0; k < NCELLS; k++) begin : g_cell
        ycconfig_cell_dec u_dec (
            .code (dec_src[3*k +: 3]),
            .ctrl (ctrl_w[9*k +: 9])
        );
    end

    assign bus.ctrl = ctrl_w;
endmodule
